// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control unit.
// The datapath is walked through IF/ID/EXE/MEM/WB one state per clock. The
// write enables and selects are decoded combinationally from the registered
// state and the op/funct fields. A 32-bit counter records retired instructions.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE  = 6'b000000,
  parameter logic [5:0] OP_ORI    = 6'b001101,
  parameter logic [5:0] OP_ADDI   = 6'b001000,
  parameter logic [5:0] OP_LUI    = 6'b001111,
  parameter logic [5:0] OP_LW     = 6'b100011,
  parameter logic [5:0] OP_SW     = 6'b101011,
  parameter logic [5:0] OP_BEQ    = 6'b000100,
  parameter logic [5:0] OP_REGIMM = 6'b000001,
  parameter logic [5:0] OP_J      = 6'b000010,
  parameter logic [5:0] OP_JAL    = 6'b000011,
  parameter logic [5:0] F_ADDU    = 6'h21,
  parameter logic [5:0] F_SUBU    = 6'h23,
  parameter logic [5:0] F_SLT     = 6'h2a,
  parameter logic [5:0] F_JR      = 6'h08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        overflow,
  input  logic        bltzal_sign,
  output logic        PC_write,
  output logic        IR_write,
  output logic        Reg_write,
  output logic        Mem_write,
  output logic        ALU_Src,
  output logic [2:0]  ALU_op,
  output logic [1:0]  PC_src,
  output logic [1:0]  Reg_dst,
  output logic [1:0]  Wb_src,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      nxt_state_s;
  logic [31:0] retired_r;
  logic        ovf_r;

  logic        is_rtype_s;
  logic        is_r_alu_s;
  logic        is_jr_s;
  logic        goes_exe_s;

  logic        pc_write_s;
  logic        ir_write_s;
  logic        reg_write_s;
  logic        mem_write_s;
  logic        alu_src_s;
  logic [2:0]  alu_op_s;
  logic [1:0]  pc_src_s;
  logic [1:0]  reg_dst_s;
  logic [1:0]  wb_src_s;

  // Instruction classification shared by the ID and WB decisions.
  always_comb begin
    is_rtype_s = (op == OP_RTYPE);
    is_r_alu_s = is_rtype_s && ((funct == F_ADDU) || (funct == F_SUBU) || (funct == F_SLT));
    is_jr_s    = is_rtype_s && (funct == F_JR);
    goes_exe_s = is_r_alu_s || (op == OP_ORI) || (op == OP_ADDI) || (op == OP_LUI) ||
                 (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_REGIMM);
  end

  // Next-state and control decode; everything defaults to idle/zero first.
  always_comb begin
    nxt_state_s = S_IF;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    alu_src_s   = 1'b0;
    alu_op_s    = 3'b000;
    pc_src_s    = 2'b00;
    reg_dst_s   = 2'b00;
    wb_src_s    = 2'b00;
    case (state_r)
      S_IF: begin
        ir_write_s  = 1'b1;
        pc_write_s  = 1'b1;
        pc_src_s    = 2'b00;
        nxt_state_s = S_ID;
      end
      S_ID: begin
        if (op == OP_J) begin
          pc_write_s  = 1'b1;
          pc_src_s    = 2'b10;
          nxt_state_s = S_IF;
        end else if (is_jr_s) begin
          pc_write_s  = 1'b1;
          pc_src_s    = 2'b11;
          nxt_state_s = S_IF;
        end else if (op == OP_JAL) begin
          pc_write_s  = 1'b1;
          pc_src_s    = 2'b10;
          reg_write_s = 1'b1;
          reg_dst_s   = 2'b10;
          wb_src_s    = 2'b10;
          nxt_state_s = S_IF;
        end else if (goes_exe_s) begin
          nxt_state_s = S_EXE;
        end else begin
          // Unknown opcode or funct: drop the instruction silently.
          nxt_state_s = S_IF;
        end
      end
      S_EXE: begin
        case (op)
          OP_RTYPE: begin
            case (funct)
              F_ADDU:  alu_op_s = 3'b000;
              F_SUBU:  alu_op_s = 3'b001;
              F_SLT:   alu_op_s = 3'b011;
              default: alu_op_s = 3'b000;
            endcase
            nxt_state_s = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op_s    = 3'b000;
            alu_src_s   = 1'b1;
            nxt_state_s = S_MEM;
          end
          OP_ORI: begin
            alu_op_s    = 3'b010;
            alu_src_s   = 1'b1;
            nxt_state_s = S_WB;
          end
          OP_ADDI: begin
            alu_op_s    = 3'b100;
            alu_src_s   = 1'b1;
            nxt_state_s = S_WB;
          end
          OP_LUI: begin
            alu_op_s    = 3'b101;
            alu_src_s   = 1'b1;
            nxt_state_s = S_WB;
          end
          OP_BEQ: begin
            alu_op_s = 3'b001;
            if (zero) begin
              pc_write_s = 1'b1;
              pc_src_s   = 2'b01;
            end else begin
              pc_write_s = 1'b0;
            end
            nxt_state_s = S_IF;
          end
          OP_REGIMM: begin
            alu_op_s = 3'b110;
            if (bltzal_sign) begin
              pc_write_s  = 1'b1;
              pc_src_s    = 2'b01;
              reg_write_s = 1'b1;
              reg_dst_s   = 2'b10;
              wb_src_s    = 2'b10;
            end else begin
              pc_write_s = 1'b0;
            end
            nxt_state_s = S_IF;
          end
          default: nxt_state_s = S_IF;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          mem_write_s = 1'b1;
          nxt_state_s = S_IF;
        end else if (op == OP_LW) begin
          nxt_state_s = S_WB;
        end else begin
          nxt_state_s = S_IF;
        end
      end
      S_WB: begin
        // An overflowing addi completes but leaves the register file untouched.
        reg_write_s = !((op == OP_ADDI) && ovf_r);
        reg_dst_s   = is_rtype_s ? 2'b01 : 2'b00;
        wb_src_s    = (op == OP_LW) ? 2'b01 : 2'b00;
        nxt_state_s = S_IF;
      end
      default: nxt_state_s = S_IF;
    endcase
  end

  // Output drive; reset silences every enable and select immediately.
  always_comb begin
    if (rst) begin
      PC_write  = 1'b0;
      IR_write  = 1'b0;
      Reg_write = 1'b0;
      Mem_write = 1'b0;
      ALU_Src   = 1'b0;
      ALU_op    = 3'b000;
      PC_src    = 2'b00;
      Reg_dst   = 2'b00;
      Wb_src    = 2'b00;
    end else begin
      PC_write  = pc_write_s;
      IR_write  = ir_write_s;
      Reg_write = reg_write_s;
      Mem_write = mem_write_s;
      ALU_Src   = alu_src_s;
      ALU_op    = alu_op_s;
      PC_src    = pc_src_s;
      Reg_dst   = reg_dst_s;
      Wb_src    = wb_src_s;
    end
    state   = state_r;
    retired = retired_r;
  end

  // State register, retire counter and the EXE-sampled overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IF;
      retired_r <= 32'd0;
      ovf_r     <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      if ((state_r != S_IF) && (nxt_state_s == S_IF)) begin
        retired_r <= retired_r + 32'd1;
      end else begin
        retired_r <= retired_r;
      end
      if (state_r == S_EXE) begin
        ovf_r <= overflow;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. An instruction-level model
// (class, step index and latency table) predicts every output on every cycle.
// Directed sequences pin the model with literal expectations.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ORI = 6'b001101, OP_ADDI = 6'b001000,
                         OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_REGIMM = 6'b000001, OP_J = 6'b000010,
                         OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_SLT = 6'h2a, F_JR = 6'h08;

  localparam int C_ADDU = 0, C_SUBU = 1, C_SLT = 2, C_JR = 3, C_BAD = 4, C_ORI = 5,
                 C_ADDI = 6, C_LUI = 7, C_LW = 8, C_SW = 9, C_BEQ = 10, C_BLTZAL = 11,
                 C_J = 12, C_JAL = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, funct;
  logic        zero, overflow, bltzal_sign;
  logic        PC_write, IR_write, Reg_write, Mem_write, ALU_Src;
  logic [2:0]  ALU_op, state;
  logic [1:0]  PC_src, Reg_dst, Wb_src;
  logic [31:0] retired;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
    .bltzal_sign(bltzal_sign), .PC_write(PC_write), .IR_write(IR_write),
    .Reg_write(Reg_write), .Mem_write(Mem_write), .ALU_Src(ALU_Src), .ALU_op(ALU_op),
    .PC_src(PC_src), .Reg_dst(Reg_dst), .Wb_src(Wb_src), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  // Model state
  int          m_step;
  logic [31:0] m_ret;
  logic        m_ovf;
  // Expected outputs for the current cycle
  logic        e_pcw, e_irw, e_rw, e_mw, e_asrc;
  logic [2:0]  e_aop, e_state;
  logic [1:0]  e_psrc, e_rdst, e_wbs;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_RTYPE:  return (f == F_ADDU) ? C_ADDU : (f == F_SUBU) ? C_SUBU :
                        (f == F_SLT) ? C_SLT : (f == F_JR) ? C_JR : C_BAD;
      OP_ORI:    return C_ORI;
      OP_ADDI:   return C_ADDI;
      OP_LUI:    return C_LUI;
      OP_LW:     return C_LW;
      OP_SW:     return C_SW;
      OP_BEQ:    return C_BEQ;
      OP_REGIMM: return C_BLTZAL;
      OP_J:      return C_J;
      OP_JAL:    return C_JAL;
      default:   return C_BAD;
    endcase
  endfunction

  // Cycles from IF until the next IF.
  function automatic int len_of(input int c);
    case (c)
      C_J, C_JR, C_JAL, C_BAD: return 2;
      C_BEQ, C_BLTZAL:         return 3;
      C_LW:                    return 5;
      default:                 return 4;
    endcase
  endfunction

  function automatic logic [2:0] state_at(input int c, input int k);
    if (k <= 2) return 3'(k);
    if (k == 3) return (c == C_LW || c == C_SW) ? 3'd3 : 3'd4;
    return 3'd4;
  endfunction

  // Predict this cycle's outputs from current inputs and model position.
  task automatic expect_now();
    int c;
    c = cls_of(op, funct);
    {e_pcw, e_irw, e_rw, e_mw, e_asrc} = 5'b0;
    e_aop = 3'd0; e_psrc = 2'd0; e_rdst = 2'd0; e_wbs = 2'd0;
    e_state = state_at(c, m_step);
    if (!rst) begin
      if (e_state == 3'd0) begin
        e_irw = 1'b1; e_pcw = 1'b1;
      end else if (e_state == 3'd1) begin
        if (c == C_J)  begin e_pcw = 1'b1; e_psrc = 2'd2; end
        if (c == C_JR) begin e_pcw = 1'b1; e_psrc = 2'd3; end
        if (c == C_JAL) begin
          e_pcw = 1'b1; e_psrc = 2'd2; e_rw = 1'b1; e_rdst = 2'd2; e_wbs = 2'd2;
        end
      end else if (e_state == 3'd2) begin
        case (c)
          C_ADDU:      begin e_aop = 3'd0; e_asrc = 1'b0; end
          C_LW, C_SW:  begin e_aop = 3'd0; e_asrc = 1'b1; end
          C_SUBU:      begin e_aop = 3'd1; e_asrc = 1'b0; end
          C_BEQ: begin
            e_aop = 3'd1;
            if (zero) begin e_pcw = 1'b1; e_psrc = 2'd1; end
          end
          C_ORI:  begin e_aop = 3'd2; e_asrc = 1'b1; end
          C_SLT:  begin e_aop = 3'd3; e_asrc = 1'b0; end
          C_ADDI: begin e_aop = 3'd4; e_asrc = 1'b1; end
          C_LUI:  begin e_aop = 3'd5; e_asrc = 1'b1; end
          C_BLTZAL: begin
            e_aop = 3'd6;
            if (bltzal_sign) begin
              e_pcw = 1'b1; e_psrc = 2'd1; e_rw = 1'b1; e_rdst = 2'd2; e_wbs = 2'd2;
            end
          end
          default: ;
        endcase
      end else if (e_state == 3'd3) begin
        e_mw = (c == C_SW);
      end else begin
        e_rw = !(c == C_ADDI && m_ovf);
        e_rdst = (c == C_ADDU || c == C_SUBU || c == C_SLT) ? 2'd1 : 2'd0;
        e_wbs = (c == C_LW) ? 2'd1 : 2'd0;
      end
    end
  endtask

  // Move the model past the coming clock edge.
  task automatic model_edge();
    int c;
    c = cls_of(op, funct);
    if (rst) begin
      m_step = 0; m_ret = 32'd0; m_ovf = 1'b0;
    end else begin
      if (m_step == 2) m_ovf = overflow;
      if (m_step == len_of(c) - 1) begin
        m_step = 0; m_ret = m_ret + 32'd1;
      end else begin
        m_step = m_step + 1;
      end
    end
  endtask

  // Predict, then wait until just after the negedge compare.
  task automatic step();
    expect_now();
    @(negedge clk);
    #1;
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic ov, input logic sg, input logic r);
    op = o; funct = f; zero = z; overflow = ov; bltzal_sign = sg; rst = r;
    step();
  endtask

  // Single compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state", int'(state), int'(e_state));
      cmp("retired", int'(retired), int'(m_ret));
      cmp("PC_write", int'(PC_write), int'(e_pcw));
      cmp("IR_write", int'(IR_write), int'(e_irw));
      cmp("Reg_write", int'(Reg_write), int'(e_rw));
      cmp("Mem_write", int'(Mem_write), int'(e_mw));
      cmp("ALU_Src", int'(ALU_Src), int'(e_asrc));
      cmp("ALU_op", int'(ALU_op), int'(e_aop));
      cmp("PC_src", int'(PC_src), int'(e_psrc));
      cmp("Reg_dst", int'(Reg_dst), int'(e_rdst));
      cmp("Wb_src", int'(Wb_src), int'(e_wbs));
    end
  end

  initial begin
    logic [5:0] o, f;
    rst = 1'b1; op = OP_LW; funct = 6'h00; zero = 1'b0; overflow = 1'b0; bltzal_sign = 1'b0;
    m_step = 0; m_ret = 32'd0; m_ovf = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Second reset cycle: everything quiet, IF, counter zero.
    drive(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("lit_rst_state", int'(state), 0);
    cmp("lit_rst_retired", int'(retired), 0);
    cmp("lit_rst_irw", int'(IR_write), 0);
    advance();

    // lw walks all five states; only WB writes the register file from memory.
    for (int k = 0; k < 5; k++) begin
      drive(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      cmp("lit_lw_state", int'(state), k);
      cmp("lit_lw_regwrite", int'(Reg_write), (k == 4) ? 1 : 0);
      if (k == 4) cmp("lit_lw_wbsrc", int'(Wb_src), 1);
      advance();
    end

    // beq taken then not taken, three cycles each.
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 3; k++) begin
        drive(OP_BEQ, 6'h00, (n == 0), 1'b0, 1'b0, 1'b0);
        if (k == 0) cmp("lit_beq_retired", int'(retired), 1 + n);
        cmp("lit_beq_state", int'(state), k);
        if (k == 2) begin
          cmp("lit_beq_pcw", int'(PC_write), (n == 0) ? 1 : 0);
          cmp("lit_beq_pcsrc", int'(PC_src), (n == 0) ? 1 : 0);
        end
        advance();
      end
    end

    // addi with overflow then without.
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) begin
        drive(OP_ADDI, 6'h00, 1'b0, (n == 0), 1'b0, 1'b0);
        if (k == 0) cmp("lit_addi_retired", int'(retired), 3 + n);
        if (k == 3) begin
          cmp("lit_addi_state", int'(state), 4);
          cmp("lit_addi_regwrite", int'(Reg_write), (n == 0) ? 0 : 1);
          cmp("lit_addi_regdst", int'(Reg_dst), 0);
        end
        advance();
      end
    end

    // jal resolves in ID.
    drive(OP_JAL, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    drive(OP_JAL, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("lit_jal_pcw", int'(PC_write), 1);
    cmp("lit_jal_pcsrc", int'(PC_src), 2);
    cmp("lit_jal_rw", int'(Reg_write), 1);
    cmp("lit_jal_rdst", int'(Reg_dst), 2);
    cmp("lit_jal_wbs", int'(Wb_src), 2);
    advance();

    // Unknown opcode: IF, ID (silent), IF.
    drive(6'b111111, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("lit_bad_state0", int'(state), 0);
    cmp("lit_bad_irw", int'(IR_write), 1);
    advance();
    drive(6'b111111, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("lit_bad_en", int'({PC_write, IR_write, Reg_write, Mem_write}), 0);
    advance();
    drive(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("lit_bad_next_state", int'(state), 0);
    cmp("lit_bad_retired", int'(retired), 7);
    advance();

    // sw aborted by reset in MEM.
    for (int k = 0; k < 3; k++) begin
      drive(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    end
    drive(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("lit_sw_rst_state", int'(state), 3);
    cmp("lit_sw_rst_mw", int'(Mem_write), 0);
    advance();
    drive(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("lit_sw_after_state", int'(state), 0);
    cmp("lit_sw_after_retired", int'(retired), 0);
    advance();

    // Randomized instruction stream with occasional resets.
    o = OP_SW; f = 6'h00;
    for (int i = 0; i < 4000; i++) begin
      if (m_step == 0) begin
        case ($urandom_range(0, 15))
          0:  o = OP_RTYPE;  1: o = OP_RTYPE;  2: o = OP_ORI;   3: o = OP_ADDI;
          4:  o = OP_LUI;    5: o = OP_LW;     6: o = OP_SW;    7: o = OP_BEQ;
          8:  o = OP_REGIMM; 9: o = OP_J;      10: o = OP_JAL;  11: o = 6'b111111;
          12: o = 6'($urandom); 13: o = OP_ADDI; 14: o = OP_RTYPE;
          default: o = OP_LW;
        endcase
        case ($urandom_range(0, 4))
          0: f = F_ADDU; 1: f = F_SUBU; 2: f = F_SLT; 3: f = F_JR;
          default: f = 6'($urandom);
        endcase
      end
      drive(o, f, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));
      advance();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
